fetch_queue_unit: RTL and testbench
===================================

# fetch_queue_unit

Parametrised next-generation instruction fetch stage. It owns the PC, issues one outstanding request at a time to the instruction cache with a read/resp handshake, and picks the next PC from the execute-stage redirect and the branch, jump and return predictors. Fetched instructions and their prediction metadata go into a DEPTH-entry circular queue. Decode drains the queue with a valid/ready handshake, so icache latency is decoupled from decode stalls.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `HIST_W`, 5: branch history width.
- `RESET_PC`, 32'h0000_0060: PC loaded on reset.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `imem_read` out 1: fetch request; held until `imem_resp`.
- `imem_addr` out 32: fetch address; stable while `imem_read`=1.
- `imem_resp` in 1: one-cycle response strobe.
- `imem_rdata` in 32: instruction; valid with `imem_resp`.
- `redirect_valid` in 1: execute misprediction or flush.
- `redirect_pc` in 32: corrected PC.
- `pred_taken` in 1: branch predicted taken for `imem_addr`.
- `pred_target` in 32: branch target.
- `pred_history` in HIST_W: history snapshot.
- `jump_hit` in 1: jump predictor hit.
- `jump_target` in 32: jump target.
- `ret_hit` in 1: return predictor hit.
- `ret_target` in 32: return target.
- `dec_valid` out 1: queue head valid.
- `dec_ready` in 1: decode accepts the head.
- `dec_pc` out 32: head PC.
- `dec_instr` out 32: head instruction.
- `dec_branch_guess` out 1: head `pred_taken`.
- `dec_history` out HIST_W: head history.
- `dec_jump_det` out 1: head `jump_hit`.
- `pc_next_val` out 32: next-PC value, for RVFI.

## Operation
State machine states:
- IDLE: `imem_read`=0.
- FETCH: `imem_read`=1, `imem_addr`=`pc`.
- SQUASH: `imem_read`=1, `imem_addr`=`req_addr`, and the response is dropped.

Definitions:
- `count_next` = count + push − pop.
- `space` = (`count_next` < DEPTH).

Reset:
- `pc`=RESET_PC, state IDLE.
- Queue empty, pointers 0, storage zeroed.
- All outputs 0 except `pc_next_val`=RESET_PC+4.

Next-PC priority, evaluated when a response arrives:
1. `pred_taken` → `pred_target`.
2. `jump_hit` → `jump_target`.
3. `ret_hit` → `ret_target`.
4. Otherwise `pc`+4.

A redirect loads {`redirect_pc[31:1]`,1'b0} and overrides everything else.

IDLE:
- On redirect, load `pc`.
- Go to FETCH if `space`, else stay in IDLE.

FETCH:
- `imem_resp` without redirect:
  - Push {`pc`, `imem_rdata`, `pred_taken`, `pred_history`, `jump_hit`}.
  - Load the next-PC into `pc`.
  - Go to FETCH if `space`, else IDLE.
- Redirect without resp:
  - Capture `req_addr` ← `pc`.
  - Load `pc` from the redirect.
  - Flush the queue and go to SQUASH.
- Redirect with resp in the same cycle:
  - Drop the response, load `pc` from the redirect, flush the queue.
  - Go to FETCH (the queue is now empty).

SQUASH:
- On resp, drop the data and go to FETCH.
- A redirect here reloads `pc` only.

Queue:
- Head pops when `dec_valid`&&`dec_ready`.
- Pointers wrap modulo DEPTH.
- Flush outranks same-cycle push and pop: count=0 and head=tail.
- No bypass from empty: an entry pushed in cycle N is visible at N+1.
- Push at full cannot happen, because FETCH is entered only with a reserved slot.
- `dec_*` fields always reflect the head entry storage.

## Timing
- `rst` deasserted at cycle 0 → `imem_read`=1 with `imem_addr`=RESET_PC at cycle 1.
- Response at cycle N → `dec_valid` at N+1; next `imem_addr` at N+1 with `imem_read` kept high.
- Throughput is one instruction per cycle for a same-cycle-response cache.
- Redirect at cycle R:
  - The queue is empty and `dec_valid`=0 at R+1.
  - The first fetch at `redirect_pc` is issued at R+1, or one cycle after the dropped response.
- Predictor inputs are sampled only in the response cycle, and are combinational on `imem_addr`.
- `rst` mid-request:
  - Returns to reset state at the next edge.
  - A later stray `imem_resp` in IDLE is ignored.

## Configuration
- `FETCH_RAS_EN` defined: `ret_hit` and `ret_target` take part in the priority as step 3.
- Not defined: the return-prediction logic is compiled out, the ports remain but are ignored, and next-PC falls through to `pc`+4.

## Test plan
- Reset, then cache answering 1 cycle after request with `dec_ready`=1 → `dec_pc` sequence 0x60, 0x64, 0x68, one per response.
- `pred_taken`=1 with target 0x200 at fetch of 0x64 → next `imem_addr`=0x200; that entry has `dec_branch_guess`=1 and `dec_history` equal to the driven value.
- DEPTH=4 with `dec_ready`=0 → exactly 4 entries queued, then `imem_read`=0. Raising `dec_ready` for one cycle → fetch resumes next cycle.
- `redirect_valid` with `redirect_pc`=0x301 while waiting in a 3-cycle miss:
  - `imem_addr` holds the old PC until resp and that response is dropped.
  - Next `imem_addr`=0x300; the queue is empty.
- `redirect_valid` in the same cycle as `imem_resp` and a pop → nothing pushed, count=0, next `imem_addr`=`redirect_pc`.
- `ret_hit`=1 with `ret_target`=0x400:
  - With `FETCH_RAS_EN` → next `imem_addr`=0x400.
  - Without it → next `imem_addr`=`pc`+4.
  - With `jump_hit` also set → `jump_target` wins.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch stage with next-PC prediction and decode queue
//
// Owns the PC, keeps one icache request outstanding at a time and buffers
// fetched instructions plus prediction metadata in a DEPTH-entry circular
// queue that decode drains with a valid/ready handshake.
//
// Optional feature macro: FETCH_RAS_EN (return predictor joins the next-PC
// priority; when undefined ret_hit/ret_target are ignored).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_read, imem_addr     fetch request and address (held until imem_resp)
//   imem_resp, imem_rdata    one-cycle response strobe and instruction
//   redirect_valid/_pc       execute-stage flush and corrected PC
//   pred_taken/_target/_history, jump_hit/_target, ret_hit/_target
//                            predictor lookups for imem_addr
//   dec_valid, dec_ready     queue head handshake towards decode
//   dec_pc, dec_instr, dec_branch_guess, dec_history, dec_jump_det
//                            head entry fields
//   pc_next_val              next-PC value for tracing
module fetch_queue_unit #(
  parameter int          DEPTH    = 4,
  parameter int          HIST_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_read,
  output logic [31:0]       imem_addr,
  input  logic              imem_resp,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              pred_taken,
  input  logic [31:0]       pred_target,
  input  logic [HIST_W-1:0] pred_history,
  input  logic              jump_hit,
  input  logic [31:0]       jump_target,
  input  logic              ret_hit,
  input  logic [31:0]       ret_target,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [31:0]       dec_pc,
  output logic [31:0]       dec_instr,
  output logic              dec_branch_guess,
  output logic [HIST_W-1:0] dec_history,
  output logic              dec_jump_det,
  output logic [31:0]       pc_next_val
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        pc;
  logic [31:0]        req_addr;
  logic [31:0]        pc_d;
  logic [31:0]        pred_next;
  logic [31:0]        redirect_target;

  logic [31:0]        q_pc    [DEPTH];
  logic [31:0]        q_instr [DEPTH];
  logic               q_taken [DEPTH];
  logic [HIST_W-1:0]  q_hist  [DEPTH];
  logic               q_jump  [DEPTH];
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_next;

  logic               push;
  logic               pop;
  logic               flush;
  logic               space;
  logic               unused_bits;

  assign redirect_target = {redirect_pc[31:1], 1'b0};

  // Priority is built lowest-first so the later assignments win.
  always_comb begin
    pred_next = pc + 32'd4;
`ifdef FETCH_RAS_EN
    if (ret_hit) pred_next = ret_target;
`endif
    if (jump_hit) pred_next = jump_target;
    if (pred_taken) pred_next = pred_target;
  end

`ifdef FETCH_RAS_EN
  assign unused_bits = redirect_pc[0];
`else
  assign unused_bits = ^{redirect_pc[0], ret_hit, ret_target};
`endif

  // Any redirect flushes: whatever is queued was fetched down the wrong path.
  assign flush      = redirect_valid;
  assign push       = (state == FETCH) && imem_resp && !redirect_valid;
  assign pop        = dec_valid && dec_ready;
  assign count_next = flush ? '0 : (count + CW'(push) - CW'(pop));
  // A request is only issued when the slot for its response is reserved.
  assign space      = (count_next < CW'(DEPTH));

  assign pc_d = redirect_valid                   ? redirect_target :
                ((state == FETCH) && imem_resp)  ? pred_next       : pc;

  assign pc_next_val = redirect_valid ? redirect_target : pred_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_addr  <= '0;
      imem_read <= 1'b0;
      imem_addr <= '0;
    end else begin
      pc <= pc_d;
      case (state)
        IDLE: begin
          if (space) begin
            state     <= FETCH;
            imem_read <= 1'b1;
            imem_addr <= pc_d;
          end
        end
        FETCH: begin
          if (redirect_valid && !imem_resp) begin
            // Request still in flight: keep its address on the bus and
            // throw away the response when it finally comes back.
            state    <= SQUASH;
            req_addr <= pc;
          end else if (imem_resp) begin
            if (space) begin
              imem_addr <= pc_d;
            end else begin
              state     <= IDLE;
              imem_read <= 1'b0;
              imem_addr <= '0;
            end
          end
        end
        SQUASH: begin
          if (imem_resp) begin
            state     <= FETCH;
            imem_addr <= pc_d;
          end
        end
        default: begin
          state     <= IDLE;
          imem_read <= 1'b0;
          imem_addr <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      q_pc    <= '{default: '0};
      q_instr <= '{default: '0};
      q_taken <= '{default: '0};
      q_hist  <= '{default: '0};
      q_jump  <= '{default: '0};
    end else begin
      count <= count_next;
      if (flush) begin
        head <= tail;
      end else begin
        if (push) begin
          q_pc[tail]    <= pc;
          q_instr[tail] <= imem_rdata;
          q_taken[tail] <= pred_taken;
          q_hist[tail]  <= pred_history;
          q_jump[tail]  <= jump_hit;
          tail          <= tail + PW'(1);
        end
        if (pop) head <= head + PW'(1);
      end
    end
  end

  assign dec_valid        = (count != '0);
  assign dec_pc           = q_pc[head];
  assign dec_instr        = q_instr[head];
  assign dec_branch_guess = q_taken[head];
  assign dec_history      = q_hist[head];
  assign dec_jump_det     = q_jump[head];

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;

  localparam int DEPTH = 4;
  localparam int HW    = 5;
`ifdef FETCH_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          taken;
    logic [HW-1:0] hist;
    logic          jump;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_read;
  logic [31:0]   imem_addr;
  logic          imem_resp;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic [HW-1:0] pred_history;
  logic          jump_hit;
  logic [31:0]   jump_target;
  logic          ret_hit;
  logic [31:0]   ret_target;
  logic          dec_valid;
  logic          dec_ready;
  logic [31:0]   dec_pc;
  logic [31:0]   dec_instr;
  logic          dec_branch_guess;
  logic [HW-1:0] dec_history;
  logic          dec_jump_det;
  logic [31:0]   pc_next_val;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_queue_unit #(.DEPTH(DEPTH), .HIST_W(HW), .RESET_PC(32'h0000_0060)) dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_addr(imem_addr),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_history(pred_history),
    .jump_hit(jump_hit), .jump_target(jump_target),
    .ret_hit(ret_hit), .ret_target(ret_target),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_instr(dec_instr),
    .dec_branch_guess(dec_branch_guess), .dec_history(dec_history),
    .dec_jump_det(dec_jump_det), .pc_next_val(pc_next_val)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic tk,
                                           input logic [31:0] ptgt, input logic jh,
                                           input logic [31:0] jtgt, input logic rh,
                                           input logic [31:0] rtgt);
    if (tk) return ptgt;
    if (jh) return jtgt;
    if (rh && RAS_EN) return rtgt;
    return pc + 32'd4;
  endfunction

  task automatic clear_inputs;
    imem_resp = 0; imem_rdata = 0; redirect_valid = 0; redirect_pc = 0;
    pred_taken = 0; pred_target = 0; pred_history = 0; jump_hit = 0;
    jump_target = 0; ret_hit = 0; ret_target = 0; dec_ready = 0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_cmp++; if (imem_read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b expected 0", imem_read); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    n_cmp++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
    n_cmp++; if ({dec_pc, dec_instr, dec_branch_guess, dec_history, dec_jump_det} !== '0) begin
      n_fail++; $display("FAIL reset_dec_fields: got %h/%h expected 0", dec_pc, dec_instr); end
    n_cmp++; if (pc_next_val !== 32'h64) begin n_fail++; $display("FAIL reset_pc_next_val: got %h expected 00000064", pc_next_val); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_read !== 1'b1) begin n_fail++; $display("FAIL first_read: got %b expected 1", imem_read); end
    n_cmp++; if (imem_addr !== 32'h60) begin n_fail++; $display("FAIL first_addr: got %h expected 00000060", imem_addr); end
  endtask

  task automatic test_sequential;
    int got = 0;
    int lat_cnt = 0;
    do_reset();
    dec_ready = 1'b1;
    for (int c = 0; c < 40 && got < 3; c++) begin
      if (dec_valid) begin
        n_cmp++;
        if (dec_pc !== 32'h60 + 32'(4 * got)) begin
          n_fail++; $display("FAIL seq_dec_pc[%0d]: got %h expected %h", got, dec_pc, 32'h60 + 32'(4 * got));
        end
        got++;
      end
      imem_resp = 1'b0;
      if (imem_read) begin
        if (lat_cnt == 1) begin imem_resp = 1'b1; imem_rdata = $urandom; lat_cnt = 0; end
        else lat_cnt++;
      end
      @(negedge clk);
    end
    n_cmp++; if (got != 3) begin n_fail++; $display("FAIL seq_timeout: got %0d entries expected 3", got); end
    clear_inputs();
  endtask

  task automatic test_pred;
    logic [HW-1:0] h;
    h = HW'($urandom);
    do_reset();
    @(negedge clk);
    imem_resp = 1'b1; imem_rdata = $urandom;
    @(negedge clk);
    n_cmp++; if (imem_addr !== 32'h64) begin n_fail++; $display("FAIL pred_addr64: got %h expected 00000064", imem_addr); end
    pred_taken = 1'b1; pred_target = 32'h200; pred_history = h; imem_rdata = $urandom;
    @(negedge clk);
    clear_inputs();
    n_cmp++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL pred_target_addr: got %h expected 00000200", imem_addr); end
    n_cmp++; if ({dec_pc, dec_branch_guess} !== {32'h60, 1'b0}) begin
      n_fail++; $display("FAIL pred_head0: got %h/%b expected 00000060/0", dec_pc, dec_branch_guess); end
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    n_cmp++; if ({dec_pc, dec_branch_guess, dec_history} !== {32'h64, 1'b1, h}) begin
      n_fail++; $display("FAIL pred_entry: got %h/%b/%h expected 00000064/1/%h", dec_pc, dec_branch_guess, dec_history, h); end
  endtask

  task automatic test_depth_stall;
    int nresp = 0;
    do_reset();
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      if (!imem_read) break;
      imem_resp = 1'b1; imem_rdata = $urandom; nresp++;
      @(negedge clk);
    end
    imem_resp = 1'b0;
    n_cmp++; if (nresp != DEPTH) begin n_fail++; $display("FAIL depth_count: got %0d expected %0d", nresp, DEPTH); end
    n_cmp++; if (imem_read !== 1'b0) begin n_fail++; $display("FAIL depth_idle: got %b expected 0", imem_read); end
    @(negedge clk);
    n_cmp++; if (imem_read !== 1'b0) begin n_fail++; $display("FAIL depth_hold_idle: got %b expected 0", imem_read); end
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    n_cmp++; if ({imem_read, imem_addr} !== {1'b1, 32'h70}) begin
      n_fail++; $display("FAIL depth_resume: got %b/%h expected 1/00000070", imem_read, imem_addr); end
    n_cmp++; if (dec_pc !== 32'h64) begin n_fail++; $display("FAIL depth_head: got %h expected 00000064", dec_pc); end
  endtask

  task automatic test_redirect_miss;
    do_reset();
    @(negedge clk);
    imem_resp = 1'b1; imem_rdata = $urandom;
    @(negedge clk);
    imem_resp = 1'b0;
    n_cmp++; if ({dec_valid, imem_addr} !== {1'b1, 32'h64}) begin
      n_fail++; $display("FAIL miss_pre: got %b/%h expected 1/00000064", dec_valid, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h301;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_cmp++; if ({dec_valid, imem_read, imem_addr} !== {1'b0, 1'b1, 32'h64}) begin
      n_fail++; $display("FAIL miss_hold1: got %b/%b/%h expected 0/1/00000064", dec_valid, imem_read, imem_addr); end
    @(negedge clk);
    n_cmp++; if (imem_addr !== 32'h64) begin n_fail++; $display("FAIL miss_hold2: got %h expected 00000064", imem_addr); end
    imem_resp = 1'b1; imem_rdata = $urandom;
    @(negedge clk);
    n_cmp++; if ({dec_valid, imem_read, imem_addr} !== {1'b0, 1'b1, 32'h300}) begin
      n_fail++; $display("FAIL miss_refetch: got %b/%b/%h expected 0/1/00000300", dec_valid, imem_read, imem_addr); end
    @(negedge clk);
    imem_resp = 1'b0;
    n_cmp++; if ({dec_valid, dec_pc, imem_addr} !== {1'b1, 32'h300, 32'h304}) begin
      n_fail++; $display("FAIL miss_first_entry: got %b/%h/%h expected 1/00000300/00000304", dec_valid, dec_pc, imem_addr); end
  endtask

  task automatic test_redirect_same_cycle;
    logic [31:0] tgt;
    tgt = ($urandom & 32'h0000_FFFC) | 32'h0001_0000;
    do_reset();
    @(negedge clk);
    imem_resp = 1'b1;
    repeat (2) @(negedge clk);
    dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = tgt;
    @(negedge clk);
    clear_inputs();
    n_cmp++; if ({dec_valid, imem_read, imem_addr} !== {1'b0, 1'b1, tgt}) begin
      n_fail++; $display("FAIL same_cycle_redirect: got %b/%b/%h expected 0/1/%h", dec_valid, imem_read, imem_addr, tgt); end
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    n_cmp++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL same_cycle_empty: got %b expected 0", dec_valid); end
  endtask

  task automatic test_ret;
    do_reset();
    dec_ready = 1'b1;
    @(negedge clk);
    imem_resp = 1'b1; ret_hit = 1'b1; ret_target = 32'h400;
    @(negedge clk);
    n_cmp++; if (imem_addr !== (RAS_EN ? 32'h400 : 32'h64)) begin
      n_fail++; $display("FAIL ret_only: got %h expected %h", imem_addr, RAS_EN ? 32'h400 : 32'h64); end
    jump_hit = 1'b1; jump_target = 32'h480;
    @(negedge clk);
    clear_inputs();
    n_cmp++; if (imem_addr !== 32'h480) begin n_fail++; $display("FAIL ret_vs_jump: got %h expected 00000480", imem_addr); end
  endtask

  task automatic test_rst_mid;
    do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({imem_read, dec_valid} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid: got %b/%b expected 0/0", imem_read, dec_valid); end
    rst = 1'b0; imem_resp = 1'b1; imem_rdata = $urandom;
    @(negedge clk);
    imem_resp = 1'b0;
    n_cmp++; if ({dec_valid, imem_read, imem_addr} !== {1'b0, 1'b1, 32'h60}) begin
      n_fail++; $display("FAIL stray_resp: got %b/%b/%h expected 0/1/00000060", dec_valid, imem_read, imem_addr); end
  endtask

  task automatic test_random;
    ent_t        mq[$];
    ent_t        e;
    logic [31:0] fetch_pc, sq_addr;
    bit          squashing, rdy, rsp, rdr;
    int          lat_cnt, lat_sel;
    do_reset();
    @(negedge clk);
    fetch_pc = 32'h60; sq_addr = 0; squashing = 0;
    lat_cnt = 0; lat_sel = $urandom_range(0, 3);
    for (int c = 0; c < 1500; c++) begin
      n_cmp++; if (dec_valid !== (mq.size() != 0)) begin
        n_fail++; $display("FAIL rnd_dec_valid c%0d: got %b expected %0d entries", c, dec_valid, mq.size()); end
      if (mq.size() != 0) begin
        n_cmp++; if ({dec_pc, dec_instr, dec_branch_guess, dec_history, dec_jump_det} !== mq[0]) begin
          n_fail++; $display("FAIL rnd_head c%0d: got pc %h instr %h expected pc %h instr %h", c, dec_pc, dec_instr, mq[0].pc, mq[0].instr); end
      end
      n_cmp++; if (imem_read !== (mq.size() < DEPTH)) begin
        n_fail++; $display("FAIL rnd_read c%0d: got %b with %0d queued", c, imem_read, mq.size()); end
      if (imem_read) begin
        n_cmp++; if (imem_addr !== (squashing ? sq_addr : fetch_pc)) begin
          n_fail++; $display("FAIL rnd_addr c%0d: got %h expected %h", c, imem_addr, squashing ? sq_addr : fetch_pc); end
      end
      rdy = ($urandom_range(0, 2) != 0);
      rsp = 1'b0;
      if (imem_read) begin
        if (lat_cnt >= lat_sel) begin rsp = 1'b1; lat_cnt = 0; lat_sel = $urandom_range(0, 3); end
        else lat_cnt++;
      end else lat_cnt = 0;
      rdr = ($urandom_range(0, 29) == 0);
      dec_ready = rdy; imem_resp = rsp; imem_rdata = $urandom;
      redirect_valid = rdr; redirect_pc = $urandom;
      pred_taken = ($urandom_range(0, 3) == 0); pred_target = $urandom & 32'hFFFF_FFFC;
      pred_history = HW'($urandom);
      jump_hit = ($urandom_range(0, 3) == 0); jump_target = $urandom & 32'hFFFF_FFFC;
      ret_hit = ($urandom_range(0, 3) == 0); ret_target = $urandom & 32'hFFFF_FFFC;
      if (rdr) begin
        mq.delete();
        if (rsp) squashing = 1'b0;
        else if (imem_read && !squashing) begin squashing = 1'b1; sq_addr = fetch_pc; end
        fetch_pc = {redirect_pc[31:1], 1'b0};
      end else begin
        if (rdy && mq.size() != 0) void'(mq.pop_front());
        if (rsp) begin
          if (squashing) squashing = 1'b0;
          else begin
            e.pc = fetch_pc; e.instr = imem_rdata; e.taken = pred_taken;
            e.hist = pred_history; e.jump = jump_hit;
            mq.push_back(e);
            fetch_pc = ref_next(fetch_pc, pred_taken, pred_target, jump_hit, jump_target, ret_hit, ret_target);
          end
        end
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_pred();
    test_depth_stall();
    test_redirect_miss();
    test_redirect_same_cycle();
    test_ret();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
